// File: rtl/latq_regfile.sv
// rtl/latq_regfile.sv - latch-array register file: DEPTH x W words, one write port, one registered read port
// Word enables come from CLK-low-transparent gate latches, so they open only in the high phase of the issuing cycle.
module latq_regfile #(
  parameter int W      = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic          WE,
  input  logic [AW-1:0] WA,
  input  logic [W-1:0]  D,
  input  logic [AW-1:0] RA,
  output logic [W-1:0]  Q
);

  logic             r_we_q;
  logic [AW-1:0]    r_wa_q;
  logic [W-1:0]     r_d_q;
  logic [DEPTH-1:0] r_g;
  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_en;
  logic             w_wa_ok;
  logic             w_ra_ok;

  assign w_wa_ok = (int'(WA) < DEPTH);
  assign w_ra_ok = (int'(RA) < DEPTH);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = WE && (int'(WA) == i);
    end
  end

  // Gate latches freeze during the high phase, so WA/WE movement there cannot reach the enables.
  always_latch begin
    if (!RN) begin
      r_g <= '0;
    end else if (!CLK) begin
      r_g <= w_sel;
    end
  end

  assign w_en = {DEPTH{CLK}} & r_g;

  always_latch begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!RN) begin
        r_mem[i] <= '0;
      end else if (w_en[i] && r_we_q && (int'(r_wa_q) == i)) begin
        r_mem[i] <= r_d_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_we_q <= 1'b0;
      r_wa_q <= '0;
      r_d_q  <= '0;
      Q      <= '0;
    end else begin
      r_we_q <= WE && w_wa_ok;
      r_wa_q <= WA;
      r_d_q  <= D;
      if (!w_ra_ok) begin
        Q <= '0;
      end else if ((BYPASS != 0) && WE && w_wa_ok && (RA == WA)) begin
        Q <= D;
      end else begin
        Q <= r_mem[RA];
      end
    end
  end

endmodule

// File: tb/tb_latq_regfile.sv
// tb/tb_latq_regfile.sv - self-checking bench for latq_regfile (three configurations driven in lockstep)
// Instances: BYPASS=0/DEPTH=8, BYPASS=1/DEPTH=8, BYPASS=1/DEPTH=6.
module tb_latq_regfile;

  logic       CLK;
  logic       RN;
  logic       WE;
  logic [2:0] WA;
  logic [7:0] D;
  logic [2:0] RA;
  logic [7:0] q_b0, q_b1, q_d6;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] m_b0 [8];
  logic [7:0] m_b1 [8];
  logic [7:0] m_d6 [8];
  logic [7:0] e_b0, e_b1, e_d6;

  latq_regfile #(.W(8), .DEPTH(8), .BYPASS(0)) u_b0 (
    .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .D(D), .RA(RA), .Q(q_b0));
  latq_regfile #(.W(8), .DEPTH(8), .BYPASS(1)) u_b1 (
    .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .D(D), .RA(RA), .Q(q_b1));
  latq_regfile #(.W(8), .DEPTH(6), .BYPASS(1)) u_d6 (
    .CLK(CLK), .RN(RN), .WE(WE), .WA(WA), .D(D), .RA(RA), .Q(q_d6));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_b0[i] = 8'h00;
      m_b1[i] = 8'h00;
      m_d6[i] = 8'h00;
    end
    e_b0 = 8'h00;
    e_b1 = 8'h00;
    e_d6 = 8'h00;
  endtask

  // Reference: read sees the array before this edge's write, except the same-edge bypass case.
  task automatic model_edge(input logic we, input int wa, input logic [7:0] d, input int ra);
    e_b0 = m_b0[ra];
    e_b1 = (we && wa == ra) ? d : m_b1[ra];
    if (ra >= 6) e_d6 = 8'h00;
    else         e_d6 = (we && wa < 6 && wa == ra) ? d : m_d6[ra];
    if (we) begin
      m_b0[wa] = d;
      m_b1[wa] = d;
      if (wa < 6) m_d6[wa] = d;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_b0"}, q_b0, e_b0);
    check({tag, "_b1"}, q_b1, e_b1);
    check({tag, "_d6"}, q_d6, e_d6);
  endtask

  // Called at a falling edge; returns at the next falling edge after checking Q.
  task automatic cycle(input string tag, input logic we, input int wa, input logic [7:0] d,
                       input int ra, input bit glitch);
    WE = we;
    WA = 3'(wa);
    D  = d;
    RA = 3'(ra);
    @(posedge CLK);
    model_edge(we, wa, d, ra);
    if (glitch) begin
      #1 WA = 3'd0;
      #1 WA = 3'd4;
      #1 WA = 3'd0;
      #1 WA = 3'd4;
      WE = 1'b0;
    end
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 8; a++) cycle(tag, 1'b0, 0, 8'h00, a, 1'b0);
  endtask

  initial begin
    RN = 1'b0;
    WE = 1'b0;
    WA = 3'd0;
    D  = 8'h00;
    RA = 3'd0;
    model_clear();
    repeat (2) @(negedge CLK);
    check_all("reset_state");
    RN = 1'b1;

    // Preload, then a write to 3 interrupted by reset in its high phase.
    for (int a = 0; a < 8; a++) cycle("preload", 1'b1, a, 8'(8'h40 + a), a, 1'b0);
    WE = 1'b1; WA = 3'd3; D = 8'hA5; RA = 3'd3;
    @(posedge CLK);
    #2 RN = 1'b0;
    #1;
    model_clear();
    check_all("reset_async_q");
    @(negedge CLK);
    WE = 1'b0;
    RN = 1'b1;
    sweep("reset_sweep");

    cycle("latency_wr", 1'b1, 2, 8'h3C, 2, 1'b0);
    cycle("latency_rd", 1'b0, 0, 8'h00, 2, 1'b0);

    cycle("b2b_1", 1'b1, 5, 8'h11, 0, 1'b0);
    cycle("b2b_2", 1'b1, 5, 8'h22, 5, 1'b0);
    cycle("b2b_3", 1'b1, 6, 8'h33, 5, 1'b0);
    cycle("b2b_rd6", 1'b0, 0, 8'h00, 6, 1'b0);
    sweep("b2b_sweep");

    cycle("oor_wr", 1'b1, 7, 8'hFF, 7, 1'b0);
    cycle("oor_rd", 1'b0, 0, 8'h00, 7, 1'b0);
    sweep("oor_sweep");

    cycle("glitch_wr", 1'b1, 1, 8'h5A, 0, 1'b0);
    cycle("glitch_wr2", 1'b1, 1, 8'h6B, 1, 1'b1);
    cycle("glitch_rd", 1'b0, 0, 8'h00, 1, 1'b0);
    sweep("glitch_sweep");

    for (int n = 0; n < 300; n++) begin
      cycle("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            8'($urandom), int'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0));
    end
    sweep("final_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
